// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 3x3 receptive-field convolution: per kij it resets the core, streams the
// kernel SRAM->L0->PE, streams receptive-field activations SRAM->L0, executes and drains.
module conv_seq_ctrl #(
    parameter int          M         = 6,
    parameter int          K         = 3,
    parameter int          COL       = 8,
    parameter int          LEN_NIJ   = 16,
    parameter logic [10:0] WGT_BASE  = 11'h400,
    parameter int          RST_CYC   = 5,
    parameter int          GAP_CYC   = 5,
    parameter int          LOAD_CYC  = 20,
    parameter int          DRAIN_CYC = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx,
    output logic        core_reset,
    output logic [6:0]  inst,
    output logic        cen_act_wgt,
    output logic        wen_act_wgt,
    output logic [10:0] addr_act_wgt
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CMAX = max2(max2(max2(RST_CYC, COL), max2(GAP_CYC, LOAD_CYC)),
                               max2(LEN_NIJ, DRAIN_CYC));
    localparam int CW   = $clog2(CMAX + 1);
    localparam int OW   = M - K + 1;
    localparam int OXW  = (OW > 1) ? $clog2(OW) : 1;
    localparam int KJW  = (K > 1) ? $clog2(K) : 1;

    localparam logic [CW-1:0]  C_RST    = CW'(RST_CYC);
    localparam logic [CW-1:0]  C_COL    = CW'(COL);
    localparam logic [CW-1:0]  C_LEN    = CW'(LEN_NIJ);
    localparam logic [3:0]     LAST_KIJ = 4'(K * K - 1);
    localparam logic [OXW-1:0] LAST_OX  = OXW'(OW - 1);
    localparam logic [KJW-1:0] LAST_KJ  = KJW'(K - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CRST, S_W_RD, S_W_GAP, S_W_LD, S_W_SET,
        S_A_RD, S_A_GAP, S_EXEC, S_DRAIN, S_NEXT_KIJ, S_DONE
    } state_t;

    state_t          state, state_d, succ;
    logic [CW-1:0]   cnt, cnt_d, last_cnt;
    logic [3:0]      kij_d;
    logic [10:0]     wgt_ptr, kij_base, act_row;
    logic [OXW-1:0]  ox;
    logic [KJW-1:0]  kj;
    logic            rd_w, rd_a, l0_wr_d, l0_rd_d, load_d, exec_d, busy_d;

    always_comb begin
        last_cnt = '0;
        succ     = state;
        case (state)
            S_CRST:  begin last_cnt = C_RST;              succ = S_W_RD;  end
            S_W_RD:  begin last_cnt = C_COL;              succ = S_W_GAP; end
            S_W_GAP: begin last_cnt = CW'(GAP_CYC - 1);   succ = S_W_LD;  end
            S_W_LD:  begin last_cnt = CW'(COL - 1);       succ = S_W_SET; end
            S_W_SET: begin last_cnt = CW'(LOAD_CYC - 1);  succ = S_A_RD;  end
            S_A_RD:  begin last_cnt = C_LEN;              succ = S_A_GAP; end
            S_A_GAP: begin last_cnt = CW'(GAP_CYC - 1);   succ = S_EXEC;  end
            S_EXEC:  begin last_cnt = CW'(LEN_NIJ - 1);   succ = S_DRAIN; end
            S_DRAIN: begin
                last_cnt = CW'(DRAIN_CYC - 1);
                succ     = (kij_idx == LAST_KIJ) ? S_DONE : S_NEXT_KIJ;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        kij_d   = kij_idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CRST;
                    cnt_d   = '0;
                    kij_d   = '0;
                end
            end
            S_NEXT_KIJ: begin
                state_d = S_CRST;
                cnt_d   = '0;
                kij_d   = kij_idx + 4'd1;
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (cnt == last_cnt) begin
                    state_d = succ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
        endcase
    end

    // Strobes are decoded from the next state so the registered outputs line up with the state.
    always_comb begin
        rd_w    = (state_d == S_W_RD) && (cnt_d < C_COL);
        rd_a    = (state_d == S_A_RD) && (cnt_d < C_LEN);
        l0_wr_d = ((state_d == S_W_RD) || (state_d == S_A_RD)) && (cnt_d != '0);
        l0_rd_d = (state_d == S_W_LD) || (state_d == S_EXEC);
        load_d  = (state_d == S_W_LD);
        exec_d  = (state_d == S_EXEC);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            kij_idx      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            core_reset   <= 1'b0;
            inst         <= '0;
            cen_act_wgt  <= 1'b1;
            wen_act_wgt  <= 1'b1;
            addr_act_wgt <= '0;
            wgt_ptr      <= WGT_BASE;
            kij_base     <= '0;
            act_row      <= '0;
            ox           <= '0;
            kj           <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            kij_idx     <= kij_d;
            busy        <= busy_d;
            done        <= (state_d == S_DONE);
            core_reset  <= (state_d == S_CRST) && (cnt_d < C_RST);
            inst        <= {1'b0, busy_d & kij_d[0], 1'b0, l0_rd_d, l0_wr_d, exec_d, load_d};
            cen_act_wgt <= ~(rd_w | rd_a);
            wen_act_wgt <= 1'b1;

            if (state == S_IDLE && start) begin
                wgt_ptr  <= WGT_BASE;
                kij_base <= '0;
                kj       <= '0;
            end else if (state == S_NEXT_KIJ) begin
                wgt_ptr <= wgt_ptr + 11'(COL);
                if (kj == LAST_KJ) begin
                    kj       <= '0;
                    kij_base <= kij_base + 11'(M - K + 1);
                end else begin
                    kj       <= kj + KJW'(1);
                    kij_base <= kij_base + 11'd1;
                end
            end

            // Addresses advance from the previous read address; reads within a phase are back-to-back.
            if (rd_w) begin
                addr_act_wgt <= (cnt_d == '0) ? wgt_ptr : addr_act_wgt + 11'd1;
            end else if (rd_a) begin
                if (cnt_d == '0) begin
                    addr_act_wgt <= kij_base;
                    act_row      <= kij_base;
                    ox           <= '0;
                end else if (ox == LAST_OX) begin
                    addr_act_wgt <= act_row + 11'(M);
                    act_row      <= act_row + 11'(M);
                    ox           <= '0;
                end else begin
                    addr_act_wgt <= addr_act_wgt + 11'd1;
                    ox           <= ox + OXW'(1);
                end
            end else begin
                addr_act_wgt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: captures whole runs cycle by cycle and checks them
// against hand-derived timing and address expectations.
module tb_conv_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        busy, done, core_reset, cen_act_wgt, wen_act_wgt;
    logic [3:0]  kij_idx;
    logic [6:0]  inst;
    logic [10:0] addr_act_wgt;

    always #5 clk = ~clk;

    conv_seq_ctrl #(
        .M(6), .K(3), .COL(8), .LEN_NIJ(16), .WGT_BASE(11'h400),
        .RST_CYC(5), .GAP_CYC(5), .LOAD_CYC(20), .DRAIN_CYC(100)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .kij_idx(kij_idx), .core_reset(core_reset), .inst(inst),
        .cen_act_wgt(cen_act_wgt), .wen_act_wgt(wen_act_wgt), .addr_act_wgt(addr_act_wgt)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    localparam int TMAX     = 2500;
    localparam int RUN_LEN  = 1683;
    localparam int KIJ_LEN  = 187;

    logic [6:0]  t_inst [TMAX];
    logic [10:0] t_addr [TMAX];
    logic [3:0]  t_kij  [TMAX];
    logic        t_cen  [TMAX];
    logic        t_wen  [TMAX];
    logic        t_cr   [TMAX];
    logic        t_busy [TMAX];
    logic        t_done [TMAX];
    int          n;

    int exp_act4 [16] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};
    int exp_act8 [16] = '{14, 15, 16, 17, 20, 21, 22, 23, 26, 27, 28, 29, 32, 33, 34, 35};

    task automatic check_reset_vals(input string tag);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".kij"}, 32'(kij_idx), 0);
        check({tag, ".core_reset"}, 32'(core_reset), 0);
        check({tag, ".inst"}, 32'(inst), 0);
        check({tag, ".cen"}, 32'(cen_act_wgt), 1);
        check({tag, ".wen"}, 32'(wen_act_wgt), 1);
        check({tag, ".addr"}, 32'(addr_act_wgt), 0);
    endtask

    // Raises start at the current negedge and records every cycle until done (bounded).
    task automatic capture(input bit hold, input int pulse_kij, output bit ok, output bit pulsed);
        ok = 1'b0;
        pulsed = 1'b0;
        n = 0;
        start = 1'b1;
        for (int c = 0; c < TMAX; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (pulse_kij >= 0 && !pulsed && kij_idx == 4'(pulse_kij) && inst[1]) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            t_inst[n] = inst;  t_addr[n] = addr_act_wgt; t_kij[n] = kij_idx;
            t_cen[n]  = cen_act_wgt; t_wen[n] = wen_act_wgt; t_cr[n] = core_reset;
            t_busy[n] = busy;  t_done[n] = done;
            n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic analyze(input string tag);
        int kcnt [9];
        int rdc  [9];
        logic [10:0] rd [9][24];
        int loads = 0, execs = 0, l0wr = 0, l0wr_bad = 0, overlap = 0, rchip_bad = 0;
        int fixed_bad = 0, idle_addr_bad = 0, busy_bad = 0, dones = 0, kij_bad = 0, cr = 0;
        int exp_a, a, oy, ox;
        for (int k = 0; k < 9; k++) begin
            kcnt[k] = 0;
            rdc[k] = 0;
        end
        check({tag, ".len"}, 32'(n), 32'(RUN_LEN));
        for (int i = 0; i < n; i++) begin
            if (t_kij[i] > 4'd8) begin
                kij_bad++;
                continue;
            end
            kcnt[t_kij[i]]++;
            if (t_inst[i][0]) loads++;
            if (t_inst[i][1]) execs++;
            if (t_inst[i][2]) begin
                l0wr++;
                if (i == 0 || t_cen[i-1]) l0wr_bad++;
            end
            if ((t_inst[i][0] && t_inst[i][1]) || (t_inst[i][2] && t_inst[i][3])) overlap++;
            if (t_busy[i] && (t_inst[i][5] != t_kij[i][0])) rchip_bad++;
            if (t_inst[i][6] || t_inst[i][4] || !t_wen[i]) fixed_bad++;
            if (t_cen[i] && t_addr[i] != 11'd0) idle_addr_bad++;
            if (i < n - 1 && !t_busy[i]) busy_bad++;
            if (t_done[i]) dones++;
            if (!t_cen[i]) begin
                if (rdc[t_kij[i]] < 24) rd[t_kij[i]][rdc[t_kij[i]]] = t_addr[i];
                rdc[t_kij[i]]++;
            end
        end
        check({tag, ".kij_range"}, 32'(kij_bad), 0);
        check({tag, ".load_total"}, 32'(loads), 72);
        check({tag, ".exec_total"}, 32'(execs), 144);
        check({tag, ".l0wr_total"}, 32'(l0wr), 216);
        check({tag, ".l0wr_lag"}, 32'(l0wr_bad), 0);
        check({tag, ".strobe_overlap"}, 32'(overlap), 0);
        check({tag, ".rchip_track"}, 32'(rchip_bad), 0);
        check({tag, ".fixed_bits"}, 32'(fixed_bad), 0);
        check({tag, ".idle_addr"}, 32'(idle_addr_bad), 0);
        check({tag, ".busy_held"}, 32'(busy_bad), 0);
        check({tag, ".done_count"}, 32'(dones), 1);
        if (n > 0) begin
            check({tag, ".done_last"}, 32'(t_done[n-1]), 1);
            check({tag, ".busy_with_done"}, 32'(t_busy[n-1]), 0);
        end
        if (n >= 30) begin
            for (int i = 0; i < 6; i++) if (t_cr[i]) cr++;
            check({tag, ".crst_len"}, 32'(cr), 5);
            check({tag, ".crst_first"}, 32'(t_cr[0]), 1);
            check({tag, ".crst_low"}, 32'(t_cr[5]), 0);
            check({tag, ".load_pre"}, 32'(t_inst[19][0]), 0);
            check({tag, ".load_first"}, 32'({t_inst[20][0], t_inst[20][3]}), 3);
            check({tag, ".load_last"}, 32'({t_inst[27][0], t_inst[27][3]}), 3);
            check({tag, ".load_post"}, 32'(t_inst[28][0]), 0);
            check({tag, ".l0wr_kij0_first"}, 32'({t_cen[6], t_inst[6][2], t_inst[7][2]}), 1);
        end
        for (int k = 0; k < 9; k++) begin
            check($sformatf("%s.kij%0d_cycles", tag, k), 32'(kcnt[k]), 32'(KIJ_LEN));
            check($sformatf("%s.kij%0d_reads", tag, k), 32'(rdc[k]), 24);
            if (n >= RUN_LEN)
                check($sformatf("%s.kij%0d_rchip", tag, k), 32'(t_inst[k*KIJ_LEN][5]), 32'(k % 2));
            if (rdc[k] != 24) continue;
            for (int t = 0; t < 24; t++) begin
                if (t < 8) begin
                    exp_a = 'h400 + k * 8 + t;
                end else begin
                    a = t - 8; oy = a / 4; ox = a % 4;
                    exp_a = (k / 3 + oy) * 6 + (k % 3) + ox;
                    if (k == 4) exp_a = exp_act4[a];
                    if (k == 8) exp_a = exp_act8[a];
                end
                check($sformatf("%s.kij%0d_addr%0d", tag, k, t), 32'(rd[k][t]), 32'(exp_a));
            end
        end
        if (rdc[8] > 0) check({tag, ".kij8_wgt_base"}, 32'(rd[8][0]), 'h440);
    endtask

    initial begin
        bit ok, pulsed, found;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);
        check("idle.busy", 32'(busy), 0);

        capture(1'b0, -1, ok, pulsed);
        check("run1.finished", 32'(ok), 1);
        analyze("run1");

        repeat (3) @(negedge clk);
        capture(1'b0, 2, ok, pulsed);
        check("pulse.applied", 32'(pulsed), 1);
        check("pulse.finished", 32'(ok), 1);
        analyze("pulse");

        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < TMAX; c++) begin
            if (kij_idx == 4'd5 && inst[1]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst.reached_kij5_exec", 32'(found), 1);
        #2 reset = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.no_resume", 32'(busy), 0);
        check("midrst.no_resume_cen", 32'(cen_act_wgt), 1);

        capture(1'b0, -1, ok, pulsed);
        check("restart.finished", 32'(ok), 1);
        check("restart.kij_start", 32'(t_kij[0]), 0);
        analyze("restart");

        repeat (3) @(negedge clk);
        capture(1'b1, -1, ok, pulsed);
        check("hold.finished", 32'(ok), 1);
        @(negedge clk);
        check("hold.idle_busy", 32'(busy), 0);
        check("hold.idle_crst", 32'(core_reset), 0);
        @(negedge clk);
        check("hold.rerun_crst", 32'(core_reset), 1);
        check("hold.rerun_busy", 32'(busy), 1);
        check("hold.rerun_kij", 32'(kij_idx), 0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
